// File: rtl/bresenham_line_drawer_pkg.sv
// Shared frame-buffer definitions for the line drawer and its neighbours:
// frame geometry, coordinate/address types and the drawer state encoding.
package bresenham_line_drawer_pkg;

  localparam int H_RES  = 640;
  localparam int V_RES  = 480;
  localparam int X_W    = 10;
  localparam int Y_W    = 9;
  localparam int ADDR_W = 19;

  // Error term width: enough headroom for 2*err with any in-range endpoints
  localparam int ERR_W  = X_W + 3;

  typedef logic [X_W-1:0]           coord_x_t;
  typedef logic [Y_W-1:0]           coord_y_t;
  typedef logic [ADDR_W-1:0]        addr_t;
  typedef logic signed [ERR_W-1:0]  err_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2
  } state_t;

endpackage

// File: rtl/bresenham_line_drawer_if.sv
// Handshake and pixel-write bundle between the plot sequencer (master),
// the line drawer (slave) and the shared frame buffer write port.
interface bresenham_line_drawer_if;
  import bresenham_line_drawer_pkg::*;

  logic     start;
  logic     ready;
  coord_x_t x1;
  coord_y_t y1;
  coord_x_t x2;
  coord_y_t y2;
  logic     write_enable;
  addr_t    write_addr;
  logic     write_data;

  modport master (
    output start, x1, y1, x2, y2,
    input  ready, write_enable, write_addr, write_data
  );

  modport slave (
    input  start, x1, y1, x2, y2,
    output ready, write_enable, write_addr, write_data
  );

endinterface

// File: rtl/bresenham_line_drawer_pixel_addr.sv
// Combinational (x,y) -> y*640 + x frame buffer address using shift-add
// (640 = 512 + 128), so no multiplier is needed. Shared with other drawers.
module pixel_addr
  import bresenham_line_drawer_pkg::*;
(
  input  coord_x_t x,
  input  coord_y_t y,
  output addr_t    addr
);

  addr_t x_ext;
  addr_t y_ext;

  assign x_ext = addr_t'(x);
  assign y_ext = addr_t'(y);

  // Address wraps to ADDR_W bits for out-of-range coordinates
  assign addr = (y_ext << 9) + (y_ext << 7) + x_ext;

endmodule

// File: rtl/bresenham_line_drawer.sv
// Bresenham line rasteriser: accepts two endpoints on start, spends one
// SETUP cycle computing stepping terms, then writes one pixel per clock.
// All write outputs are zero when not writing so the port can be OR-shared.
// Optional macro LINE_CLIP_EN: off-screen pixels are stepped but not written.
module bresenham_line_drawer
  import bresenham_line_drawer_pkg::*;
(
  input logic                    clk,
  input logic                    rst,
  bresenham_line_drawer_if.slave bus
);

  state_t   state;
  state_t   state_next;

  coord_x_t end_x1;
  coord_y_t end_y1;
  coord_x_t end_x2;
  coord_y_t end_y2;

  coord_x_t cur_x;
  coord_y_t cur_y;
  err_t     dx;
  err_t     dy;
  err_t     err;
  logic     sx_pos;
  logic     sy_pos;

  coord_x_t dx_abs;
  coord_y_t dy_abs;
  err_t     dx_calc;
  err_t     dy_calc;
  err_t     e2;
  logic     step_x;
  logic     step_y;
  logic     at_end;
  logic     pix_valid;
  addr_t    pix_addr;

  pixel_addr u_pixel_addr (
    .x    (cur_x),
    .y    (cur_y),
    .addr (pix_addr)
  );

  assign at_end = (cur_x == end_x2) && (cur_y == end_y2);
  assign e2     = err <<< 1;
  assign step_x = (e2 >= dy);
  assign step_y = (e2 <= dx);

`ifdef LINE_CLIP_EN
  assign pix_valid = (cur_x < coord_x_t'(H_RES)) && (cur_y < coord_y_t'(V_RES));
`else
  assign pix_valid = 1'b1;
`endif

  // Absolute deltas from the latched endpoints, used during SETUP
  always_comb begin
    dx_abs  = (end_x2 > end_x1) ? (end_x2 - end_x1) : (end_x1 - end_x2);
    dy_abs  = (end_y2 > end_y1) ? (end_y2 - end_y1) : (end_y1 - end_y2);
    dx_calc = err_t'(dx_abs);
    dy_calc = -err_t'(dy_abs);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: a line always ends in IDLE after its final pixel
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = SETUP;
      SETUP:   state_next = DRAW;
      DRAW:    if (at_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch endpoints on accept, set up terms, then step per pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      end_x1 <= '0;
      end_y1 <= '0;
      end_x2 <= '0;
      end_y2 <= '0;
      cur_x  <= '0;
      cur_y  <= '0;
      dx     <= '0;
      dy     <= '0;
      err    <= '0;
      sx_pos <= 1'b0;
      sy_pos <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            end_x1 <= bus.x1;
            end_y1 <= bus.y1;
            end_x2 <= bus.x2;
            end_y2 <= bus.y2;
          end
        end
        SETUP: begin
          dx     <= dx_calc;
          dy     <= dy_calc;
          err    <= dx_calc + dy_calc;
          sx_pos <= (end_x1 < end_x2);
          sy_pos <= (end_y1 < end_y2);
          cur_x  <= end_x1;
          cur_y  <= end_y1;
        end
        DRAW: begin
          if (!at_end) begin
            err <= err + (step_x ? dy : '0) + (step_y ? dx : '0);
            if (step_x) cur_x <= sx_pos ? cur_x + coord_x_t'(1) : cur_x - coord_x_t'(1);
            if (step_y) cur_y <= sy_pos ? cur_y + coord_y_t'(1) : cur_y - coord_y_t'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: ready only when idle, write port zeroed unless drawing a valid pixel
  always_comb begin
    bus.ready        = 1'b0;
    bus.write_enable = 1'b0;
    bus.write_addr   = '0;
    bus.write_data   = 1'b0;
    case (state)
      IDLE: bus.ready = 1'b1;
      DRAW: begin
        if (pix_valid) begin
          bus.write_enable = 1'b1;
          bus.write_addr   = pix_addr;
          bus.write_data   = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bresenham_line_drawer.sv
// Self-checking bench for bresenham_line_drawer: directed lines plus random
// lines compared against an integer Bresenham reference model.
// Honours LINE_CLIP_EN the same way as the design.
module tb_bresenham_line_drawer;
  import bresenham_line_drawer_pkg::*;

  logic clk;
  logic rst;

  bresenham_line_drawer_if bus();

  bresenham_line_drawer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors;
  int miscompares;
  int exp_q[$];
  int got_q[$];
  int busy_cycles;

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts and reports mismatches
  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int absInt(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: plain integer Bresenham producing the list of written addresses
  function automatic void buildExpected(input int ax1, input int ay1, input int ax2, input int ay2);
    int dx, dy, sx, sy, err, e2, x, y;
    bit onscreen;
    exp_q.delete();
    dx  = absInt(ax2 - ax1);
    dy  = -absInt(ay2 - ay1);
    sx  = (ax1 < ax2) ? 1 : -1;
    sy  = (ay1 < ay2) ? 1 : -1;
    err = dx + dy;
    x   = ax1;
    y   = ay1;
    forever begin
      onscreen = (x < H_RES) && (y < V_RES);
`ifdef LINE_CLIP_EN
      if (onscreen) exp_q.push_back(y * H_RES + x);
`else
      exp_q.push_back((y * H_RES + x) % (1 << ADDR_W));
`endif
      if (x == ax2 && y == ay2) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endfunction

  // Runs one line, pokes start/endpoints while busy, collects writes and checks them
  task automatic applyStimulus(input int ax1, input int ay1, input int ax2, input int ay2);
    int guard;
    int gate_err;
    int dups;
    int exp_busy;
    got_q.delete();
    gate_err = 0;
    buildExpected(ax1, ay1, ax2, ay2);
    exp_busy = ((absInt(ax2 - ax1) > absInt(ay2 - ay1)) ? absInt(ax2 - ax1) : absInt(ay2 - ay1)) + 2;
    @(negedge clk);
    bus.x1    = coord_x_t'(ax1);
    bus.y1    = coord_y_t'(ay1);
    bus.x2    = coord_x_t'(ax2);
    bus.y2    = coord_y_t'(ay2);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
    busy_cycles = 0;
    guard       = 0;
    while (!bus.ready && guard < 2000) begin
      busy_cycles++;
      if (bus.write_enable) got_q.push_back(int'(bus.write_addr));
      else if (bus.write_addr != '0) gate_err++;
      if (bus.write_data != bus.write_enable) gate_err++;
      bus.x1    = coord_x_t'($urandom_range(0, H_RES - 1));
      bus.y1    = coord_y_t'($urandom_range(0, V_RES - 1));
      bus.x2    = coord_x_t'($urandom_range(0, H_RES - 1));
      bus.y2    = coord_y_t'($urandom_range(0, V_RES - 1));
      bus.start = 1'($urandom_range(0, 1));
      @(negedge clk);
      guard++;
    end
    bus.start = 1'b0;
    checkOutput("timeout", int'(guard >= 2000), 0);
    checkOutput("busy", busy_cycles, exp_busy);
    checkOutput("gating", gate_err, 0);
    checkOutput("count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      checkOutput("addr", (i < got_q.size()) ? got_q[i] : -1, exp_q[i]);
    dups = 0;
    for (int i = 0; i < got_q.size(); i++)
      for (int j = i + 1; j < got_q.size(); j++)
        if (got_q[i] == got_q[j]) dups++;
    checkOutput("unique", dups, 0);
  endtask

  int x1r, y1r, x2r, y2r;
  int idle_bad;

  initial begin
    vectors     = 0;
    miscompares = 0;
    bus.start   = 1'b0;
    bus.x1      = '0;
    bus.y1      = '0;
    bus.x2      = '0;
    bus.y2      = '0;
    rst         = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", int'(bus.ready), 1);
    checkOutput("rst_we", int'(bus.write_enable), 0);
    checkOutput("rst_addr", int'(bus.write_addr), 0);
    checkOutput("rst_data", int'(bus.write_data), 0);
    rst = 1'b0;

    // Horizontal: addresses 0..3, busy 5 cycles
    applyStimulus(0, 0, 3, 0);
    for (int i = 0; i < 4; i++)
      checkOutput("hz_addr", (i < got_q.size()) ? got_q[i] : -1, i);
    checkOutput("hz_busy", busy_cycles, 5);

    // Diagonal: addresses step by 641
    applyStimulus(0, 0, 3, 3);
    for (int i = 0; i < 4; i++)
      checkOutput("diag_addr", (i < got_q.size()) ? got_q[i] : -1, i * 641);

    // Steep lines in both directions
    applyStimulus(6, 3, 5, 0);
    checkOutput("steep_rev_cnt", got_q.size(), 4);
    applyStimulus(5, 0, 6, 3);
    checkOutput("steep_fwd_cnt", got_q.size(), 4);

    // Single point at the far corner
    applyStimulus(639, 479, 639, 479);
    checkOutput("corner_cnt", got_q.size(), 1);
    checkOutput("corner_addr", (got_q.size() > 0) ? got_q[0] : -1, 307199);

`ifdef LINE_CLIP_EN
    // Off-screen single point: consumed but never written
    applyStimulus(640, 0, 640, 0);
    checkOutput("clip_cnt", got_q.size(), 0);
    checkOutput("clip_busy", busy_cycles, 2);
`endif

    // Reset during the third pixel of a horizontal line
    @(negedge clk);
    bus.x1 = '0; bus.y1 = '0; bus.x2 = coord_x_t'(9); bus.y2 = '0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("pre_rst_addr", int'(bus.write_addr), 2);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_we", int'(bus.write_enable), 0);
    checkOutput("mid_rst_ready", int'(bus.ready), 1);
    checkOutput("mid_rst_addr", int'(bus.write_addr), 0);
    @(negedge clk);
    rst = 1'b0;

    // Idle quiet period: no outputs may toggle
    idle_bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.write_enable || bus.write_addr != '0 || bus.write_data || !bus.ready) idle_bad++;
    end
    checkOutput("idle_quiet", idle_bad, 0);

    // Random lines: alternating short local segments and full-frame spans
    for (int n = 0; n < 24; n++) begin
      x1r = $urandom_range(0, H_RES - 1);
      y1r = $urandom_range(0, V_RES - 1);
      if (n % 2 == 0) begin
        x2r = $urandom_range((x1r > 15) ? x1r - 15 : 0, (x1r < H_RES - 16) ? x1r + 15 : H_RES - 1);
        y2r = $urandom_range((y1r > 15) ? y1r - 15 : 0, (y1r < V_RES - 16) ? y1r + 15 : V_RES - 1);
      end else begin
        x2r = $urandom_range(0, H_RES - 1);
        y2r = $urandom_range(0, V_RES - 1);
      end
      applyStimulus(x1r, y1r, x2r, y2r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bresenham_line_drawer.md
Name: bresenham_line_drawer

Overview:
Rasterises one straight line segment into the 640x480 1-bpp frame buffer. It uses integer Bresenham stepping and emits one pixel write per clock. It sits between the plot sequencer, which supplies endpoints and a start pulse, and the frame buffer write port. That write port is shared with the fill drawer by OR-ing the outputs, so every output must be zero whenever the block is not writing.

Parameters:
H_RES, 640, frame width in pixels; address = y*H_RES + x
V_RES, 480, frame height in pixels
X_W, 10, x coordinate width
Y_W, 9, y coordinate width
ADDR_W, 19, frame buffer address width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle request; sampled only when ready=1
ready  out  1  high when idle and able to accept start
x1  in  X_W  start point x
y1  in  Y_W  start point y
x2  in  X_W  end point x
y2  in  Y_W  end point y
write_enable  out  1  pixel write strobe
write_addr  out  ADDR_W  pixel address; 0 when write_enable=0
write_data  out  1  pixel value; 1 when writing, 0 otherwise

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, ready=1; write_enable, write_addr and write_data are 0.
  - Reset mid-line aborts immediately; no further writes occur.
- States and transitions:
  - IDLE -> SETUP on the rising edge where start=1 and ready=1.
  - SETUP (1 cycle): latches endpoints and computes the stepping terms.
    - dx = |x2-x1|, dy = -|y2-y1|
    - sx = +1 if x1<x2, else -1; sy = +1 if y1<y2, else -1
    - err = dx+dy
    - cur = (x1, y1)
  - DRAW: one pixel per cycle at cur.
    - write_enable=1, write_data=1, write_addr = cur_y*H_RES + cur_x.
    - If cur == (x2,y2): go to IDLE on the next edge.
    - Otherwise: e2 = 2*err.
    - If e2 >= dy: err += dy, cur_x += sx.
    - If e2 <= dx: err += dx, cur_y += sy. Both updates may apply in the same cycle.
- ready is 0 in SETUP and DRAW. It is 0 on the first cycle after start is accepted.
- Timing: a line of N = max(|dx|,|dy|)+1 pixels takes 1+N cycles busy. ready rises the cycle after the last pixel.
- Both endpoints are drawn; a single-point line (x1=x2, y1=y2) writes exactly one pixel.
- Endpoint inputs may change freely after start is accepted; only the latched values are used. start while busy is ignored.
- Arithmetic: err and e2 are signed, X_W+3 bits, with no overflow for any in-range coordinates.
- Address multiply is implemented as (y<<9)+(y<<7)+x for H_RES=640; no DSP is required.
- Outputs are combinational from the state registers. No two writes may carry the same address within one line.

Optional Feature:
LINE_CLIP_EN
- Defined: pixels with cur_x >= H_RES or cur_y >= V_RES are still stepped through (the cycle is consumed), but write_enable, write_addr and write_data are forced to 0 for them.
- Undefined: inputs must be in range. Out-of-range pixels are written with the raw address, truncated to ADDR_W bits.

Decomposition:
- Shared package (frame_pkg): H_RES, V_RES, X_W, Y_W, ADDR_W; coordinate and address typedefs; the state enum (IDLE, SETUP, DRAW).
- One natural sub-module, pixel_addr: combinational (x,y) -> y*H_RES+x using shift-add. It is reused by the fill drawer and the display reader.

Test Plan:
- Horizontal: (0,0)->(3,0) -> writes to addrs 0,1,2,3 on consecutive cycles. ready is low for 5 cycles, then high.
- Diagonal: (0,0)->(3,3) -> addrs 0,641,1282,1923.
- Steep, reversed: (6,3)->(5,0) and (5,0)->(6,3) -> each writes exactly 4 pixels, one per row y=0..3, with x within {5,6}.
- Single point at corner: (639,479)->(639,479) -> exactly one write, addr 307199. With LINE_CLIP_EN, (640,0)->(640,0) -> no write_enable pulse, and ready returns after 2 cycles.
- Reset and idle: rst asserted during pixel 2 of (0,0)->(9,0) -> write_enable=0 and ready=1 immediately. start held while busy is ignored. All outputs stay 0 across 100 idle cycles.
